ifmap_diag_feeder: RTL and testbench
====================================

IFMAP_DIAG_FEEDER -- requirements
Module: ifmap_diag_feeder

Interface
REQ-001 SHALL have parameter PE_WIDTH, default 4, the word width of every data port.
REQ-002 SHALL have parameter ROW_LEN, default 8, the words per ifmap row (legal range 2..256).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port s_data, input, [0:PE_WIDTH-1], the ifmap word from the upstream buffer.
REQ-006 SHALL have port s_valid, input, 1, meaning s_data is valid.
REQ-007 SHALL have port s_ready, output, 1, meaning the feeder accepts s_data this cycle.
REQ-008 SHALL have ports ifmap_conn_IN_00, ifmap_conn_IN_01, ifmap_conn_IN_02, ifmap_conn_IN_10 and ifmap_conn_IN_20, each output, [0:PE_WIDTH-1], the array diagonal inputs, all registered.
REQ-009 SHALL have port out_valid, output, 1, meaning the five ifmap ports carry a valid column.
REQ-010 SHALL have port frame_done, output, 1, a one-cycle pulse on the last column of a frame.

Function
REQ-011 SHALL hold a frame buffer of 5 rows x ROW_LEN words, with row k mapped to the ports in this order: row 0 to IN_00, row 1 to IN_01, row 2 to IN_02, row 3 to IN_10, row 4 to IN_20.
REQ-012 SHALL implement exactly two states:
- LOAD: the reset state.
- STREAM.
REQ-013 In LOAD, SHALL drive s_ready=1, out_valid=0 and frame_done=0.
REQ-014 In LOAD, a handshake (s_valid & s_ready) SHALL write s_data unmodified to word index load_cnt, row-major (row = load_cnt / ROW_LEN, column = load_cnt mod ROW_LEN), then increment load_cnt.
REQ-015 When s_valid=0 in LOAD, load_cnt and buffer contents SHALL be unchanged; gaps of any length are legal.
REQ-016 On the handshake with load_cnt = 5*ROW_LEN-1, the feeder SHALL:
- clear load_cnt;
- move to STREAM;
- register column 0 onto the ports so that out_valid=1 in the next cycle.
REQ-017 In STREAM, SHALL drive s_ready=0; s_data and s_valid SHALL be ignored.
REQ-018 SHALL present column c (0..ROW_LEN-1) on the five ports with out_valid=1 exactly c+1 cycles after the final load handshake, one column per cycle with no bubbles; there is no backpressure from the array.
REQ-019 SHALL assert frame_done=1 in the same cycle as column ROW_LEN-1.
REQ-020 In the cycle after frame_done, SHALL:
- be back in LOAD with s_ready=1;
- drive out_valid=0;
- drive all ifmap ports to zero.
REQ-021 SHALL drive the ifmap ports to all-zero whenever out_valid=0.
REQ-022 Bit 0 SHALL be the MSB on every data port, matching the [0:PE_WIDTH-1] ordering of the array.
REQ-023 Buffer contents SHALL persist after streaming and be overwritten only by the next frame's loads.
REQ-024 Counter widths SHALL be $clog2(5*ROW_LEN) for load_cnt and $clog2(ROW_LEN) for col_cnt.
REQ-025 Neither counter SHALL wrap except through the LOAD-to-STREAM and STREAM-to-LOAD transitions.

Reset
REQ-026 While rst=1 at a clock edge, the feeder SHALL go to LOAD with load_cnt=0 and col_cnt=0.
REQ-027 While rst=1 at a clock edge, outputs SHALL be s_ready=0, out_valid=0, frame_done=0 and all ifmap ports=0.
REQ-028 The first cycle with rst=0 SHALL show s_ready=1.
REQ-029 Reset mid-LOAD or mid-STREAM SHALL discard the partial frame; buffer RAM need not be cleared.
REQ-030 After a mid-frame reset, a fresh full frame of 5*ROW_LEN words SHALL be required before out_valid rises.

Verification
REQ-031 SHALL cover a basic frame with ROW_LEN=4 and PE_WIDTH=4:
- stimulus: load words 0..19 with value = index mod 16, s_valid held high;
- response: 20 cycles of s_ready=1, then 4 columns where column c gives IN_00=c, IN_01=4+c, IN_02=8+c, IN_10=12+c, IN_20=c, with frame_done only at c=3.
REQ-032 SHALL cover s_valid gaps:
- stimulus: as REQ-031 with s_valid toggled 1,0,1,0,...;
- response: identical column data, and the first out_valid appears exactly 1 cycle after the 20th handshake.
REQ-033 SHALL cover STREAM ignoring input:
- stimulus: s_valid=1 with s_data=0xF throughout STREAM;
- response: s_ready=0, column data unaffected, and no word is loaded into the next frame.
REQ-034 SHALL cover reset mid-STREAM:
- stimulus: rst=1 for 1 cycle during column 1;
- response: next cycle out_valid=0, ports=0 and frame_done never pulses; a full 20-word reload then produces new columns.
REQ-035 SHALL cover back-to-back frames:
- stimulus: the second frame, values 15-index, is offered immediately after frame_done;
- response: its first word is accepted in the cycle after frame_done, and its columns are correct, with no stale data.
REQ-036 SHALL cover reset mid-LOAD:
- stimulus: rst after 7 words are loaded, then 20 new words;
- response: the columns reflect only the 20 new words.

Source files
------------

// File: rtl/ifmap_diag_feeder_if.sv
// Bundle of the upstream word stream and the diagonal column outputs of the
// ifmap feeder. The feeder sits on the slave side; the upstream buffer and
// the array (or a bench) sit on the master side.
//
// Handshake: a word moves on every rising clk edge where s_valid and s_ready
// are both 1. s_valid may rise or fall at any time and does not wait for
// s_ready. s_ready may drop without a transfer. The column side has no
// backpressure: a column is consumed in every cycle where out_valid is 1.
interface ifmap_diag_feeder_if #(
  parameter int PE_WIDTH = 4
);
  logic [0:PE_WIDTH-1] s_data;
  logic                s_valid;
  logic                s_ready;
  logic [0:PE_WIDTH-1] ifmap_conn_IN_00;
  logic [0:PE_WIDTH-1] ifmap_conn_IN_01;
  logic [0:PE_WIDTH-1] ifmap_conn_IN_02;
  logic [0:PE_WIDTH-1] ifmap_conn_IN_10;
  logic [0:PE_WIDTH-1] ifmap_conn_IN_20;
  logic                out_valid;
  logic                frame_done;
  // 1 while the feeder is streaming columns, 0 while it is loading
  logic                state_dbg;

  modport master (
    output s_data, s_valid,
    input  s_ready,
    input  ifmap_conn_IN_00, ifmap_conn_IN_01, ifmap_conn_IN_02,
    input  ifmap_conn_IN_10, ifmap_conn_IN_20,
    input  out_valid, frame_done, state_dbg
  );

  modport slave (
    input  s_data, s_valid,
    output s_ready,
    output ifmap_conn_IN_00, ifmap_conn_IN_01, ifmap_conn_IN_02,
    output ifmap_conn_IN_10, ifmap_conn_IN_20,
    output out_valid, frame_done, state_dbg
  );
endinterface

// File: rtl/ifmap_diag_feeder.sv
// Ifmap diagonal feeder: buffers one frame of 5 rows x ROW_LEN words loaded
// row-major from an upstream stream, then plays it out one column per cycle
// onto the five diagonal inputs of the PE array (row 0..4 -> IN_00, IN_01,
// IN_02, IN_10, IN_20). Loading and streaming never overlap.
module ifmap_diag_feeder #(
  parameter int PE_WIDTH = 4,
  parameter int ROW_LEN  = 8
) (
  input logic                clk,
  input logic                rst,
  ifmap_diag_feeder_if.slave bus
);

  localparam int N_WORDS = 5 * ROW_LEN;
  localparam int LCW     = $clog2(N_WORDS);
  localparam int CCW     = $clog2(ROW_LEN);
  localparam logic [LCW-1:0] LAST_WORD = LCW'(N_WORDS - 1);
  localparam logic [CCW-1:0] LAST_COL  = CCW'(ROW_LEN - 1);

  typedef enum logic {LOAD, STREAM} state_t;

  state_t              state_q, state_d;
  logic [LCW-1:0]      load_cnt_q, load_cnt_d;
  logic [CCW-1:0]      col_cnt_q, col_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic                frame_done_q, frame_done_d;
  logic [0:PE_WIDTH-1] port_q [5];
  logic [0:PE_WIDTH-1] port_d [5];
  logic [0:PE_WIDTH-1] mem_q  [N_WORDS];
  logic [0:PE_WIDTH-1] col_data [5];
  logic [LCW-1:0]      rd_addr [5];
  logic [CCW-1:0]      sel_col;
  logic                hs;

  // Ready only while loading; reset forces it low in the same cycle so the
  // first cycle out of reset already shows ready.
  assign bus.s_ready = (state_q == LOAD) && !rst;
  assign hs          = bus.s_valid && bus.s_ready;

  // While loading, the next column to present is always column 0.
  assign sel_col = (state_q == STREAM) ? col_cnt_q : '0;

  // Fetch the selected column from all five rows of the frame buffer.
  always_comb begin
    for (int k = 0; k < 5; k++) begin
      rd_addr[k]  = LCW'(k * ROW_LEN) + LCW'(sel_col);
      col_data[k] = mem_q[rd_addr[k]];
    end
  end

  // Next-state and registered-output logic of the LOAD/STREAM controller.
  always_comb begin
    state_d      = state_q;
    load_cnt_d   = load_cnt_q;
    col_cnt_d    = col_cnt_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    for (int k = 0; k < 5; k++) port_d[k] = '0;
    case (state_q)
      LOAD: begin
        if (hs) begin
          if (load_cnt_q == LAST_WORD) begin
            // Column 0 never includes the word written on this edge
            // (that word sits in the last column), so it can go out now.
            load_cnt_d  = '0;
            state_d     = STREAM;
            out_valid_d = 1'b1;
            port_d      = col_data;
            col_cnt_d   = CCW'(1);
          end else begin
            load_cnt_d = load_cnt_q + 1'b1;
          end
        end
      end
      STREAM: begin
        if (frame_done_q) begin
          state_d   = LOAD;
          col_cnt_d = '0;
        end else begin
          out_valid_d  = 1'b1;
          port_d       = col_data;
          frame_done_d = (col_cnt_q == LAST_COL);
          col_cnt_d    = (col_cnt_q == LAST_COL) ? '0 : col_cnt_q + 1'b1;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Controller state, counters and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD;
      load_cnt_q   <= '0;
      col_cnt_q    <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int k = 0; k < 5; k++) port_q[k] <= '0;
    end else begin
      state_q      <= state_d;
      load_cnt_q   <= load_cnt_d;
      col_cnt_q    <= col_cnt_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      port_q       <= port_d;
    end
  end

  // Frame buffer write; contents survive streaming and reset.
  always_ff @(posedge clk) begin
    if (hs) mem_q[load_cnt_q] <= bus.s_data;
  end

  assign bus.ifmap_conn_IN_00 = port_q[0];
  assign bus.ifmap_conn_IN_01 = port_q[1];
  assign bus.ifmap_conn_IN_02 = port_q[2];
  assign bus.ifmap_conn_IN_10 = port_q[3];
  assign bus.ifmap_conn_IN_20 = port_q[4];
  assign bus.out_valid        = out_valid_q;
  assign bus.frame_done       = frame_done_q;
  assign bus.state_dbg        = (state_q == STREAM);

endmodule

// File: tb/tb_ifmap_diag_feeder.sv
// Bench for ifmap_diag_feeder with ROW_LEN=4, PE_WIDTH=4. The reference model
// collects accepted words into a frame; once a full frame is in, it queues the
// columns the array must see, one per following cycle.
module tb_ifmap_diag_feeder;

  localparam int PW = 4;
  localparam int RL = 4;
  localparam int NW = 5 * RL;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ifmap_diag_feeder_if #(.PE_WIDTH(PW)) bus ();

  ifmap_diag_feeder #(.PE_WIDTH(PW), .ROW_LEN(RL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [3:0]  words[$];       // words of the frame being loaded
  logic [20:0] exp_q[$];       // pending columns: {done, IN_00, IN_01, IN_02, IN_10, IN_20}
  logic [20:0] cur_col = '0;   // column expected on the ports now
  logic        cur_valid = 1'b0;
  logic        last_acc = 1'b0;
  logic        tog = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: applied once per rising edge with the inputs driven
  // before that edge. The feeder accepts only while no column is on display.
  task automatic model_edge(input logic r, input logic v, input logic [3:0] d);
    logic [20:0] e;
    last_acc = 1'b0;
    if (r) begin
      words.delete();
      exp_q.delete();
      cur_valid = 1'b0;
      cur_col   = '0;
    end else begin
      if (v && !cur_valid) begin
        last_acc = 1'b1;
        words.push_back(d);
        if (words.size() == NW) begin
          for (int c = 0; c < RL; c++) begin
            e     = '0;
            e[20] = (c == RL - 1);
            for (int k = 0; k < 5; k++) e[19-4*k -: 4] = words[k*RL + c];
            exp_q.push_back(e);
          end
          words.delete();
        end
      end
      if (exp_q.size() > 0) begin
        cur_col   = exp_q.pop_front();
        cur_valid = 1'b1;
      end else begin
        cur_col   = '0;
        cur_valid = 1'b0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock cycle: drive inputs, check ready, take the edge, check outputs.
  task automatic step(input logic r, input logic v, input logic [3:0] d);
    rst         = r;
    bus.s_valid = v;
    bus.s_data  = d;
    #1;
    check("s_ready", 32'(bus.s_ready), 32'(!r && !cur_valid));
    @(posedge clk);
    model_edge(r, v, d);
    #1;
    check("out_valid",  32'(bus.out_valid),        32'(cur_valid));
    check("frame_done", 32'(bus.frame_done),       32'(cur_col[20]));
    check("state_dbg",  32'(bus.state_dbg),        32'(cur_valid));
    check("IN_00",      32'(bus.ifmap_conn_IN_00), 32'(cur_col[19:16]));
    check("IN_01",      32'(bus.ifmap_conn_IN_01), 32'(cur_col[15:12]));
    check("IN_02",      32'(bus.ifmap_conn_IN_02), 32'(cur_col[11:8]));
    check("IN_10",      32'(bus.ifmap_conn_IN_10), 32'(cur_col[7:4]));
    check("IN_20",      32'(bus.ifmap_conn_IN_20), 32'(cur_col[3:0]));
  endtask

  // Offer cnt words. kind: 0 index mod 16, 1 15-index, 2 random.
  // gap: 0 valid held high, 1 valid toggled 1,0,1,..., 2 random gaps.
  task automatic send_words(input int kind, input int gap, input int cnt);
    logic [3:0] d;
    logic       vv;
    int         tries;
    tog = 1'b1;
    for (int i = 0; i < cnt; i++) begin
      if (kind == 0)      d = 4'(i);
      else if (kind == 1) d = 4'(15 - i);
      else                d = 4'($urandom_range(0, 15));
      tries = 0;
      do begin
        if (gap == 0)      vv = 1'b1;
        else if (gap == 1) begin vv = tog; tog = ~tog; end
        else               vv = ($urandom_range(0, 2) != 0);
        step(1'b0, vv, vv ? d : 4'($urandom_range(0, 15)));
        tries++;
      end while (!last_acc && tries < 64);
      if (!last_acc) check("load_timeout", 32'(last_acc), 32'(1));
    end
  endtask

  // The RL cycles of column playout. noisy=1 keeps s_valid high with 0xF.
  task automatic stream_cols(input logic noisy);
    for (int c = 0; c < RL; c++) begin
      if (noisy) step(1'b0, 1'b1, 4'hF);
      else       step(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    repeat (3) step(1'b1, 1'b0, 4'h0);

    // basic frame, then input ignored while streaming
    send_words(0, 0, NW);
    stream_cols(1'b1);

    // alternating s_valid gaps
    send_words(0, 1, NW);
    stream_cols(1'b0);

    // back-to-back frames offered right after frame_done
    send_words(1, 0, NW);
    stream_cols(1'b1);
    send_words(0, 0, NW);
    stream_cols(1'b0);

    // reset during column 1, then a fresh full frame
    send_words(2, 2, NW);
    step(1'b0, 1'b0, 4'h0);
    step(1'b1, 1'b1, 4'hF);
    send_words(2, 2, NW);
    stream_cols(1'b0);

    // reset after 7 words, then 20 new words
    send_words(2, 0, 7);
    step(1'b1, 1'b0, 4'h0);
    send_words(2, 2, NW);
    stream_cols(1'b0);

    // random frames with idle gaps in between
    repeat (4) begin
      send_words(2, 2, NW);
      stream_cols(1'b0);
      repeat ($urandom_range(0, 3)) step(1'b0, 1'b0, 4'h0);
    end

    repeat (2) step(1'b0, 1'b0, 4'h0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
